// File: rtl/processor_led_pio_pkg.sv
// Shared register map and bus constants for the LED output PIO.
package processor_led_pio_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/processor_led_pio_blink_timer.sv
// Blink half-period timer: counts clk cycles up to the programmed period and
// toggles the blink phase at each terminal count. A zero period freezes the
// engine with phase low; a period write restarts the count from zero.
module processor_led_pio_blink_timer #(
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_wr,
    output logic                    phase
);

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic                    term_cnt;

    // Terminal count is period-1 so the phase holds for exactly period cycles.
    assign term_cnt = (cnt_q == (period - PERIOD_WIDTH'(1)));

    // Next-state for counter and phase; restart has priority over counting.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (term_cnt) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PERIOD_WIDTH'(1);
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/processor_led_pio.sv
// Avalon-MM output PIO for the board LEDs: software data register with
// atomic set/clear, per-bit hardware blink mask, registered read data and
// registered LED outputs.
module processor_led_pio
    import processor_led_pio_pkg::*;
#(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned       PERIOD_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [WIDTH-1:0]     out_port
);

    logic                    we;
    logic                    period_wr;
    logic                    phase;

    logic [WIDTH-1:0]        data_q, data_d;
    logic [WIDTH-1:0]        blink_en_q, blink_en_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [BUS_WIDTH-1:0]    readdata_q, readdata_d;
    logic [WIDTH-1:0]        out_port_q, out_port_d;
    logic [WIDTH-1:0]        wdata;

    // Bits of writedata above WIDTH/PERIOD_WIDTH are intentionally dropped.
    logic                    unused_wdata;
    assign unused_wdata = ^writedata;

    assign we        = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign period_wr = we && (address == ADDR_PERIOD);

    // Register-file write decode; at most one register changes per cycle.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (we) begin
            case (address)
                ADDR_DATA:     data_d     = wdata;
                ADDR_BLINK_EN: blink_en_d = wdata;
                ADDR_PERIOD:   period_d   = writedata[PERIOD_WIDTH-1:0];
                ADDR_OUTSET:   data_d     = data_q | wdata;
                ADDR_OUTCLEAR: data_d     = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    // Read mux, zero-extended; sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0]        = data_q;
            ADDR_BLINK_EN: readdata_d[WIDTH-1:0]        = blink_en_q;
            ADDR_PERIOD:   readdata_d[PERIOD_WIDTH-1:0] = period_q;
            ADDR_STATUS:   readdata_d[0]                = phase;
            default:       ;
        endcase
    end

    // Blinking bits are forced off during the high phase.
    always_comb begin
        out_port_d = data_q & ~(blink_en_q & {WIDTH{phase}});
    end

    // Configuration, read-data and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            readdata_q <= '0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

    processor_led_pio_blink_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_blink_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    assign readdata = readdata_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_processor_led_pio.sv
// Self-checking bench for processor_led_pio with a cycle-level reference model.
module tb_processor_led_pio;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks;
    int failures;

    // Reference model state
    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    logic [23:0] m_period;
    int          m_n;       // clk edges since the last PERIOD write
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;

    processor_led_pio #(
        .WIDTH        (8),
        .RESET_VALUE  (8'hA5),
        .PERIOD_WIDTH (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase is high during every odd-numbered block of PERIOD cycles.
    function automatic logic m_phase();
        if (m_period == 24'd0) return 1'b0;
        return ((m_n / int'(m_period)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r[7:0]  = m_data;
            3'd1: r[7:0]  = m_blink;
            3'd2: r[23:0] = m_period;
            3'd3: r[0]    = m_phase();
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_data   = RV;
        m_blink  = 8'd0;
        m_period = 24'd0;
        m_n      = 0;
        exp_out  = RV;
        exp_rd   = 32'd0;
    endtask

    // One clock edge; model advances using the inputs present at the edge.
    task automatic tick();
        logic [7:0]  nxt_out;
        logic [31:0] nxt_rd;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            nxt_out = m_data & ~(m_blink & {8{m_phase()}});
            nxt_rd  = m_read(address);
            m_n = m_n + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data   = writedata[7:0];
                    3'd1: m_blink  = writedata[7:0];
                    3'd2: begin m_period = writedata[23:0]; m_n = 0; end
                    3'd4: m_data   = m_data | writedata[7:0];
                    3'd5: m_data   = m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
            exp_out = nxt_out;
            exp_rd  = nxt_rd;
        end
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (out_port !== 8'hA5) begin
            failures++;
            $display("FAIL reset_out_port got=%h exp=%h", out_port, 8'hA5);
        end
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0);
        end
        reset_n = 1'b1;
        address = 3'd0;
        tick();
        checks++;
        if (readdata !== 32'h000000A5) begin
            failures++;
            $display("FAIL reset_read_data got=%h exp=%h", readdata, 32'h000000A5);
        end
        address = 3'd3;
        tick();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", readdata, 32'd0);
        end
    endtask

    task automatic test_set_clear();
        bus_write(3'd0, 32'h0000003C);
        bus_write(3'd4, 32'hFFFFFF81);
        bus_write(3'd5, 32'h0000000C);
        address = 3'd0;
        tick();
        checks++;
        if (out_port !== 8'hB1) begin
            failures++;
            $display("FAIL setclr_out_port got=%h exp=%h", out_port, 8'hB1);
        end
        checks++;
        if (readdata !== 32'h000000B1) begin
            failures++;
            $display("FAIL setclr_readback got=%h exp=%h", readdata, 32'h000000B1);
        end
        for (int a = 4; a <= 5; a++) begin
            address = 3'(a);
            tick();
            checks++;
            if (readdata !== 32'd0) begin
                failures++;
                $display("FAIL setclr_wo_read addr=%0d got=%h exp=0", a, readdata);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] samples [48];
        int last_t;
        int runs;
        bus_write(3'd2, 32'd4);
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'hFF);
        address = 3'd3;
        for (int i = 0; i < 48; i++) begin
            tick();
            samples[i] = out_port;
            checks++;
            if (out_port !== exp_out || readdata !== exp_rd) begin
                failures++;
                $display("FAIL blink_cycle i=%0d out=%h exp=%h rd=%h exp_rd=%h",
                         i, out_port, exp_out, readdata, exp_rd);
            end
        end
        last_t = -1;
        runs   = 0;
        for (int i = 1; i < 48; i++) begin
            if (samples[i] !== 8'hFF && samples[i] !== 8'hF0) begin
                checks++;
                failures++;
                $display("FAIL blink_level i=%0d got=%h exp=ff_or_f0", i, samples[i]);
            end
            if (samples[i] !== samples[i-1]) begin
                if (last_t >= 0) begin
                    runs++;
                    checks++;
                    if (i - last_t != 4) begin
                        failures++;
                        $display("FAIL blink_run_len at=%0d got=%0d exp=4", i, i - last_t);
                    end
                end
                last_t = i;
            end
        end
        checks++;
        if (runs < 8) begin
            failures++;
            $display("FAIL blink_run_count got=%0d exp>=8", runs);
        end
    endtask

    task automatic wait_phase_high(input string tag);
        int n;
        n = 0;
        address = 3'd3;
        while (!m_phase() && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!m_phase()) begin
            failures++;
            $display("FAIL %s_wait_phase got=0 exp=1", tag);
        end
    endtask

    task automatic test_period_change();
        wait_phase_high("pchg");
        bus_write(3'd2, 32'd2);
        address = 3'd3;
        tick();
        checks++;
        if (out_port !== 8'hFF) begin
            failures++;
            $display("FAIL pchg_restart got=%h exp=%h", out_port, 8'hFF);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (out_port !== exp_out || readdata !== exp_rd) begin
                failures++;
                $display("FAIL pchg_cycle i=%0d out=%h exp=%h rd=%h exp_rd=%h",
                         i, out_port, exp_out, readdata, exp_rd);
            end
        end
    endtask

    task automatic test_period_zero();
        wait_phase_high("pzero");
        bus_write(3'd2, 32'd0);
        address = 3'd3;
        tick();
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (out_port !== 8'hFF || out_port !== exp_out || readdata !== 32'd0) begin
                failures++;
                $display("FAIL pzero_steady i=%0d out=%h exp=%h status=%h exp=0",
                         i, out_port, 8'hFF, readdata);
            end
        end
    endtask

    task automatic test_async_reset();
        bus_write(3'd2, 32'd3);
        bus_write(3'd0, 32'h5A);
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_port !== RV || readdata !== 32'd0) begin
            failures++;
            $display("FAIL areset_immediate out=%h exp=%h rd=%h exp=0", out_port, RV, readdata);
        end
        tick();
        reset_n = 1'b1;
        for (int a = 1; a <= 2; a++) begin
            address = 3'(a);
            tick();
            checks++;
            if (readdata !== 32'd0) begin
                failures++;
                $display("FAIL areset_readback addr=%0d got=%h exp=0", a, readdata);
            end
        end
        bus_write(3'd7, 32'hFFFFFFFF);
        address = 3'd7;
        tick();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reserved_read got=%h exp=0", readdata);
        end
        address = 3'd0;
        tick();
        checks++;
        if (readdata !== 32'h000000A5 || out_port !== RV) begin
            failures++;
            $display("FAIL reserved_nochange rd=%h exp=%h out=%h exp=%h",
                     readdata, 32'h000000A5, out_port, RV);
        end
    endtask

    task automatic test_random();
        logic [2:0] a;
        for (int i = 0; i < 400; i++) begin
            a          = 3'($urandom_range(0, 7));
            address    = a;
            chipselect = ($urandom_range(0, 2) != 0);
            write_n    = ($urandom_range(0, 1) != 0);
            writedata  = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            tick();
            checks++;
            if (out_port !== exp_out || readdata !== exp_rd) begin
                failures++;
                $display("FAIL random_cycle i=%0d out=%h exp=%h rd=%h exp_rd=%h",
                         i, out_port, exp_out, readdata, exp_rd);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        model_reset();
        test_reset();
        test_set_clear();
        test_blink();
        test_period_change();
        test_period_zero();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
